// File: rtl/traffic_light_monitor_pkg.sv
// traffic_pkg: LED patterns, phase encoding, default dwell constants and monitor FSM state type
package traffic_pkg;
    localparam logic [2:0] LED_RED   = 3'b110;
    localparam logic [2:0] LED_BLUE  = 3'b011;
    localparam logic [2:0] LED_GREEN = 3'b101;
    localparam int unsigned RED_CYC_DEF    = 240_000_001;
    localparam int unsigned BLUE_CYC_DEF   = 72_000_000;
    localparam int unsigned GREEN_CYC_DEF  = 120_000_000;
    localparam int unsigned TOL_CYC_DEF    = 1024;
    localparam int unsigned GLITCH_CYC_DEF = 4;
    typedef enum logic [1:0] {PH_RED = 2'd0, PH_BLUE = 2'd1, PH_GREEN = 2'd2, PH_UNK = 2'd3} phase_e;
    typedef enum logic [1:0] {ACQUIRE, FIRST, TRACK} state_e;
    function automatic phase_e decode(input logic [2:0] led);
        return led == LED_RED ? PH_RED : led == LED_BLUE ? PH_BLUE : led == LED_GREEN ? PH_GREEN : PH_UNK;
    endfunction
    function automatic phase_e next_phase(input phase_e p);
        return p == PH_RED ? PH_BLUE : p == PH_BLUE ? PH_GREEN : PH_RED;
    endfunction
endpackage

// File: rtl/led_sync.sv
// led_sync: two-flop synchroniser with a configurable reset value
module led_sync #(
    parameter int unsigned     W       = 3,
    parameter logic [W-1:0]    RST_VAL = '1
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q, sync_q;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks RGB phase order and dwell times of a traffic light LED bus
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned RED_CYC    = RED_CYC_DEF,
    parameter int unsigned BLUE_CYC   = BLUE_CYC_DEF,
    parameter int unsigned GREEN_CYC  = GREEN_CYC_DEF,
    parameter int unsigned TOL_CYC    = TOL_CYC_DEF,
    parameter int unsigned GLITCH_CYC = GLITCH_CYC_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [2:0]  led_in,
    input  logic        clr_err,
    output logic [1:0]  phase,
    output logic        phase_valid,
    output logic [31:0] dwell_cnt,
    output logic [15:0] cycle_cnt,
    output logic        err_seq,
    output logic        err_timing,
    output logic        err_illegal,
    output logic [2:0]  err_sticky
);
    logic [2:0]  led_s;
    state_e      state_q, state_d;
    phase_e      phase_q, phase_d, ph_in;
    logic [31:0] dwell_q, dwell_d, dwell_inc, glitch_q, glitch_d;
    logic [15:0] cycle_q, cycle_d;
    logic [2:0]  sticky_q, sticky_d;
    logic [32:0] exp_cyc;
    logic        ovr_q, ovr_d, legal, in_order, underrun, overrun, e_seq, e_tim, e_ill;

    led_sync #(.W(3), .RST_VAL(3'b111)) u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d_i     (led_in),
        .q_o     (led_s)
    );

    // Outputs reflect this cycle's decision so a phase change shows as soon as the synchronised bus moves
    always_comb begin
        ph_in     = decode(led_s);
        legal     = ph_in != PH_UNK;
        exp_cyc   = phase_q == PH_RED ? 33'(RED_CYC) : phase_q == PH_BLUE ? 33'(BLUE_CYC) : 33'(GREEN_CYC);
        dwell_inc = &dwell_q ? dwell_q : dwell_q + 32'd1;
        in_order  = ph_in == next_phase(phase_q);
        underrun  = state_q == TRACK && {1'b0, dwell_q} + 33'(TOL_CYC) < exp_cyc;
        overrun   = !ovr_q && {1'b0, dwell_inc} >= exp_cyc + 33'(TOL_CYC) + 33'd1;
        state_d   = state_q;
        phase_d   = phase_q;
        dwell_d   = dwell_q;
        cycle_d   = cycle_q;
        glitch_d  = '0;
        ovr_d     = ovr_q;
        e_seq     = 1'b0;
        e_tim     = 1'b0;
        e_ill     = 1'b0;
        if (state_q == ACQUIRE) begin
            phase_d = PH_UNK;
            dwell_d = '0;
            if (legal) begin
                state_d = FIRST;
                phase_d = ph_in;
                dwell_d = 32'd1;
                ovr_d   = 1'b0;
            end
        end else if (!legal) begin
            glitch_d = glitch_q + 32'd1;
            if (glitch_d > GLITCH_CYC) begin
                e_ill   = 1'b1;
                state_d = ACQUIRE;
                phase_d = PH_UNK;
                dwell_d = '0;
            end else begin
                dwell_d = dwell_inc;
                e_tim   = overrun;
                ovr_d   = ovr_q | overrun;
            end
        end else if (ph_in != phase_q) begin
            e_seq   = !in_order;
            e_tim   = underrun;
            state_d = in_order ? TRACK : FIRST;
            phase_d = ph_in;
            dwell_d = 32'd1;
            ovr_d   = 1'b0;
            cycle_d = (state_q == TRACK && phase_q == PH_GREEN && ph_in == PH_RED && !underrun) ? cycle_q + 16'd1 : cycle_q;
        end else begin
            dwell_d = dwell_inc;
            e_tim   = overrun;
            ovr_d   = ovr_q | overrun;
        end
        sticky_d = (clr_err ? 3'b000 : sticky_q) | {e_ill, e_tim, e_seq};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ACQUIRE;
            phase_q  <= PH_UNK;
            dwell_q  <= '0;
            cycle_q  <= '0;
            glitch_q <= '0;
            ovr_q    <= 1'b0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            dwell_q  <= dwell_d;
            cycle_q  <= cycle_d;
            glitch_q <= glitch_d;
            ovr_q    <= ovr_d;
            sticky_q <= sticky_d;
        end
    end

    assign phase       = phase_d;
    assign phase_valid = state_d != ACQUIRE;
    assign dwell_cnt   = dwell_d;
    assign cycle_cnt   = cycle_d;
    assign err_seq     = e_seq;
    assign err_timing  = e_tim;
    assign err_illegal = e_ill;
    assign err_sticky  = sticky_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scenarios with hand-computed expectations
module tb_traffic_light_monitor;
    import traffic_pkg::*;
    logic        sys_clk = 1'b0, sys_rst = 1'b0, clr_err = 1'b0;
    logic [2:0]  led_in = 3'b111;
    logic [1:0]  phase;
    logic        phase_valid, err_seq, err_timing, err_illegal;
    logic [31:0] dwell_cnt;
    logic [15:0] cycle_cnt;
    logic [2:0]  err_sticky;
    int          n_vec = 0, n_fail = 0, n_seq = 0, n_tim = 0, n_ill = 0;
    logic [31:0] tim_dwell = '0;

    always #5 sys_clk = ~sys_clk;

    traffic_light_monitor #(.RED_CYC(20), .BLUE_CYC(6), .GREEN_CYC(10), .TOL_CYC(1), .GLITCH_CYC(2)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .led_in      (led_in),
        .clr_err     (clr_err),
        .phase       (phase),
        .phase_valid (phase_valid),
        .dwell_cnt   (dwell_cnt),
        .cycle_cnt   (cycle_cnt),
        .err_seq     (err_seq),
        .err_timing  (err_timing),
        .err_illegal (err_illegal),
        .err_sticky  (err_sticky)
    );

    // One bus cycle: drive at the falling edge, observe after the next falling edge
    task automatic cyc(input logic [2:0] p);
        led_in = p;
        @(negedge sys_clk);
        if (err_seq === 1'b1) n_seq++;
        if (err_illegal === 1'b1) n_ill++;
        if (err_timing === 1'b1) begin
            n_tim++;
            tim_dwell = dwell_cnt;
        end
    endtask

    task automatic hold(input logic [2:0] p, input int n);
        repeat (n) cyc(p);
    endtask

    task automatic clr_cyc(input logic [2:0] p);
        clr_err = 1'b1;
        cyc(p);
        clr_err = 1'b0;
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        hold(3'b111, 2);
        sys_rst = 1'b0;
        n_seq = 0; n_tim = 0; n_ill = 0;
        n_vec++; if (phase !== 2'd3) begin n_fail++; $display("FAIL rst_phase: got %0d want 3", phase); end
        n_vec++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", phase_valid); end
        n_vec++; if (dwell_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_dwell: got %0d want 0", dwell_cnt); end
        n_vec++; if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cycle: got %0d want 0", cycle_cnt); end
        n_vec++; if (err_sticky !== 3'b000) begin n_fail++; $display("FAIL rst_sticky: got %b want 000", err_sticky); end
        n_vec++; if ({err_seq, err_timing, err_illegal} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %b want 000", {err_seq, err_timing, err_illegal}); end
    endtask

    task automatic test_nominal;
        hold(LED_RED, 1);
        n_vec++; if (phase !== 2'd3) begin n_fail++; $display("FAIL nom_latency: got %0d want 3", phase); end
        cyc(LED_RED);
        n_vec++; if ({phase, phase_valid} !== {PH_RED, 1'b1}) begin n_fail++; $display("FAIL nom_red_start: got %0d/%b want 0/1", phase, phase_valid); end
        n_vec++; if (dwell_cnt !== 32'd1) begin n_fail++; $display("FAIL nom_red_dwell1: got %0d want 1", dwell_cnt); end
        hold(LED_RED, 18);
        hold(LED_BLUE, 6);
        n_vec++; if ({phase, dwell_cnt} !== {PH_BLUE, 32'd5}) begin n_fail++; $display("FAIL nom_blue: got %0d/%0d want 1/5", phase, dwell_cnt); end
        hold(LED_GREEN, 10);
        n_vec++; if ({phase, dwell_cnt} !== {PH_GREEN, 32'd9}) begin n_fail++; $display("FAIL nom_green: got %0d/%0d want 2/9", phase, dwell_cnt); end
        hold(LED_RED, 20);
        n_vec++; if ({phase, dwell_cnt} !== {PH_RED, 32'd19}) begin n_fail++; $display("FAIL nom_red2: got %0d/%0d want 0/19", phase, dwell_cnt); end
        n_vec++; if (cycle_cnt !== 16'd1) begin n_fail++; $display("FAIL nom_cycle: got %0d want 1", cycle_cnt); end
        n_vec++; if (n_seq + n_tim + n_ill != 0 || err_sticky !== 3'b000) begin n_fail++; $display("FAIL nom_errors: got %0d pulses sticky %b want 0 000", n_seq + n_tim + n_ill, err_sticky); end
    endtask

    task automatic test_sequence;
        hold(LED_GREEN, 2);
        n_vec++; if (n_seq != 1) begin n_fail++; $display("FAIL seq_pulse: got %0d want 1", n_seq); end
        n_vec++; if ({phase, dwell_cnt} !== {PH_GREEN, 32'd1}) begin n_fail++; $display("FAIL seq_adopt: got %0d/%0d want 2/1", phase, dwell_cnt); end
        cyc(LED_GREEN);
        n_vec++; if (err_sticky !== 3'b001) begin n_fail++; $display("FAIL seq_sticky: got %b want 001", err_sticky); end
        hold(LED_RED, 2);
        n_vec++; if (n_tim != 0) begin n_fail++; $display("FAIL seq_first_unchecked: got %0d want 0", n_tim); end
        n_vec++; if ({phase, cycle_cnt} !== {PH_RED, 16'd1}) begin n_fail++; $display("FAIL seq_no_count: got %0d/%0d want 0/1", phase, cycle_cnt); end
        hold(LED_RED, 17);
        clr_cyc(LED_RED);
    endtask

    task automatic test_timing;
        hold(LED_BLUE, 4);
        hold(LED_GREEN, 2);
        n_vec++; if (n_tim != 1) begin n_fail++; $display("FAIL tim_underrun: got %0d want 1", n_tim); end
        n_vec++; if ({phase, dwell_cnt} !== {PH_GREEN, 32'd1}) begin n_fail++; $display("FAIL tim_green_start: got %0d/%0d want 2/1", phase, dwell_cnt); end
        hold(LED_GREEN, 13);
        n_vec++; if (n_tim != 2) begin n_fail++; $display("FAIL tim_overrun_count: got %0d want 2", n_tim); end
        n_vec++; if (tim_dwell !== 32'd12) begin n_fail++; $display("FAIL tim_overrun_at: got %0d want 12", tim_dwell); end
        n_vec++; if (dwell_cnt !== 32'd14) begin n_fail++; $display("FAIL tim_green_dwell: got %0d want 14", dwell_cnt); end
        hold(LED_RED, 2);
        n_vec++; if (n_tim != 2) begin n_fail++; $display("FAIL tim_exit_rereport: got %0d want 2", n_tim); end
        n_vec++; if (cycle_cnt !== 16'd2) begin n_fail++; $display("FAIL tim_cycle: got %0d want 2", cycle_cnt); end
        n_vec++; if (err_sticky !== 3'b010) begin n_fail++; $display("FAIL tim_sticky: got %b want 010", err_sticky); end
        hold(LED_RED, 17);
        clr_cyc(LED_RED);
    endtask

    task automatic test_glitch;
        hold(LED_BLUE, 6);
        hold(LED_GREEN, 4);
        hold(3'b000, 2);
        hold(LED_GREEN, 2);
        n_vec++; if ({phase, phase_valid, dwell_cnt} !== {PH_GREEN, 1'b1, 32'd7}) begin n_fail++; $display("FAIL gl_short: got %0d/%b/%0d want 2/1/7", phase, phase_valid, dwell_cnt); end
        n_vec++; if (n_ill != 0) begin n_fail++; $display("FAIL gl_short_ill: got %0d want 0", n_ill); end
        hold(LED_GREEN, 1);
        hold(LED_RED, 2);
        n_vec++; if ({cycle_cnt, 32'(n_tim)} !== {16'd3, 32'd2}) begin n_fail++; $display("FAIL gl_edge_dwell: got %0d/%0d want 3/2", cycle_cnt, n_tim); end
        hold(LED_RED, 5);
        hold(3'b000, 3);
        n_vec++; if ({phase, dwell_cnt, 32'(n_ill)} !== {PH_RED, 32'd9, 32'd0}) begin n_fail++; $display("FAIL gl_limit: got %0d/%0d/%0d want 0/9/0", phase, dwell_cnt, n_ill); end
        cyc(3'b000);
        n_vec++; if (n_ill != 1) begin n_fail++; $display("FAIL gl_illegal: got %0d want 1", n_ill); end
        n_vec++; if ({phase, phase_valid, dwell_cnt} !== {2'd3, 1'b0, 32'd0}) begin n_fail++; $display("FAIL gl_acquire: got %0d/%b/%0d want 3/0/0", phase, phase_valid, dwell_cnt); end
        hold(LED_RED, 2);
        n_vec++; if ({phase, phase_valid, dwell_cnt} !== {PH_RED, 1'b1, 32'd1}) begin n_fail++; $display("FAIL gl_reacquire: got %0d/%b/%0d want 0/1/1", phase, phase_valid, dwell_cnt); end
        n_vec++; if (err_sticky !== 3'b100) begin n_fail++; $display("FAIL gl_sticky: got %b want 100", err_sticky); end
    endtask

    task automatic test_clear;
        hold(LED_RED, 3);
        cyc(LED_GREEN);
        cyc(LED_GREEN);
        n_vec++; if (err_seq !== 1'b1 || n_seq != 2) begin n_fail++; $display("FAIL clr_seq_pulse: got %b/%0d want 1/2", err_seq, n_seq); end
        clr_cyc(LED_GREEN);
        n_vec++; if (err_sticky !== 3'b001) begin n_fail++; $display("FAIL clr_coincident: got %b want 001", err_sticky); end
        clr_cyc(LED_GREEN);
        n_vec++; if (err_sticky !== 3'b000) begin n_fail++; $display("FAIL clr_alone: got %b want 000", err_sticky); end
    endtask

    task automatic test_reset_mid;
        hold(LED_RED, 20);
        hold(LED_BLUE, 3);
        n_vec++; if ({phase, dwell_cnt, cycle_cnt} !== {PH_BLUE, 32'd2, 16'd3}) begin n_fail++; $display("FAIL rm_pre: got %0d/%0d/%0d want 1/2/3", phase, dwell_cnt, cycle_cnt); end
        sys_rst = 1'b1;
        cyc(LED_BLUE);
        sys_rst = 1'b0;
        n_vec++; if ({phase, phase_valid, dwell_cnt, cycle_cnt} !== {2'd3, 1'b0, 32'd0, 16'd0}) begin n_fail++; $display("FAIL rm_outputs: got %0d/%b/%0d/%0d want 3/0/0/0", phase, phase_valid, dwell_cnt, cycle_cnt); end
        n_vec++; if ({err_sticky, err_seq, err_timing, err_illegal} !== 6'b0) begin n_fail++; $display("FAIL rm_errors: got %b want 000000", {err_sticky, err_seq, err_timing, err_illegal}); end
        hold(LED_GREEN, 4);
        n_vec++; if ({phase, phase_valid, dwell_cnt} !== {PH_GREEN, 1'b1, 32'd3}) begin n_fail++; $display("FAIL rm_green: got %0d/%b/%0d want 2/1/3", phase, phase_valid, dwell_cnt); end
        hold(LED_RED, 2);
        n_vec++; if (n_tim != 2) begin n_fail++; $display("FAIL rm_unchecked: got %0d want 2", n_tim); end
        n_vec++; if ({phase, cycle_cnt} !== {PH_RED, 16'd0}) begin n_fail++; $display("FAIL rm_red: got %0d/%0d want 0/0", phase, cycle_cnt); end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_sequence;
        test_timing;
        test_glitch;
        test_clear;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter RED_CYC, default 240_000_001, expected red dwell in sys_clk cycles.
REQ-002 Parameter BLUE_CYC, default 72_000_000, expected blue dwell in cycles.
REQ-003 Parameter GREEN_CYC, default 120_000_000, expected green dwell in cycles.
REQ-004 Parameter TOL_CYC, default 1024, allowed +/- dwell deviation in cycles.
REQ-005 Parameter GLITCH_CYC, default 4, maximum tolerated consecutive illegal-pattern cycles.
REQ-006 sys_clk  input  1  single clock; all logic on rising edge.
REQ-007 sys_rst  input  1  synchronous, active-high reset.
REQ-008 led_in  input  3  active-low RGB bus under observation; 110 red, 011 blue, 101 green; all other values illegal.
REQ-009 clr_err  input  1  single-cycle pulse that clears err_sticky.
REQ-010 phase  output  2  decoded phase: 0 red, 1 blue, 2 green, 3 unknown.
REQ-011 phase_valid  output  1  high while phase is tracked.
REQ-012 dwell_cnt  output  32  cycles spent in current phase, saturating at all-ones.
REQ-013 cycle_cnt  output  16  completed, checked green-to-red transitions; wraps at 65535 -> 0.
REQ-014 err_seq, err_timing, err_illegal  output  1 each  one-cycle error pulses.
REQ-015 err_sticky  output  3  {illegal, timing, seq} latched error flags.

Function
REQ-016 led_in SHALL pass a 2-flop synchroniser; all decoding uses the synchronised value (2-cycle latency).
REQ-017 The FSM SHALL have states ACQUIRE, FIRST and TRACK.
REQ-018 ACQUIRE: phase = 3, phase_valid = 0, dwell_cnt = 0; first legal pattern -> FIRST with phase set and dwell_cnt = 1.
REQ-019 FIRST: phase start was not observed; exit dwell SHALL NOT be checked for underrun.
REQ-020 A change to a different legal pattern SHALL update phase in that same cycle and restart dwell_cnt at 1.
REQ-021 Legal order SHALL be red -> blue -> green -> red; a legal order change moves FIRST/TRACK -> TRACK.
REQ-022 An out-of-order change SHALL pulse err_seq, adopt the new phase and enter FIRST.
REQ-023 Exiting a phase in TRACK with dwell < EXP - TOL_CYC SHALL pulse err_timing.
REQ-024 In FIRST or TRACK, dwell_cnt reaching EXP + TOL_CYC + 1 SHALL pulse err_timing once per phase; exit overrun SHALL NOT be re-reported.
REQ-025 An illegal pattern lasting <= GLITCH_CYC consecutive cycles SHALL be ignored: phase held, dwell_cnt keeps counting.
REQ-026 Illegal pattern on consecutive cycle GLITCH_CYC + 1 SHALL pulse err_illegal and enter ACQUIRE.
REQ-027 cycle_cnt SHALL increment on each green -> red change in TRACK that raises no err_timing.
REQ-028 Each error pulse SHALL set its err_sticky bit; clr_err clears all bits.
REQ-029 If clr_err and an error pulse coincide, the new error's sticky bit SHALL end set.
REQ-030 EXP SHALL be RED_CYC, BLUE_CYC or GREEN_CYC for the phase being timed; comparisons are 33-bit unsigned to avoid overflow.

Reset
REQ-031 On sys_rst: FSM to ACQUIRE; synchroniser flops 3'b111; phase = 3; phase_valid = 0; dwell_cnt, cycle_cnt, err_sticky = 0; all pulses low.
REQ-032 Reset mid-phase SHALL discard the partial measurement; the next phase is treated as FIRST.

Structure
REQ-033 Package traffic_pkg SHALL hold LED pattern constants (RED/BLUE/GREEN), the phase encoding, the default dwell constants and the FSM state type.
REQ-034 The synchroniser SHALL be a sub-module named led_sync (2-flop, width 3, reset value 3'b111).

Verification (RED_CYC=20, BLUE_CYC=6, GREEN_CYC=10, TOL_CYC=1, GLITCH_CYC=2)
REQ-035 Test 1, nominal sequence: red 20, blue 6, green 10, red 20 cycles -> no errors; cycle_cnt = 1; phase tracks the input 2 cycles late.
REQ-036 Test 2, sequence error: red -> green directly -> err_seq pulse; err_sticky = 001; next green dwell of 3 unchecked.
REQ-037 Test 3, timing: blue held 4 cycles in TRACK -> err_timing at exit; green held 15 -> err_timing pulse once at dwell_cnt = 12.
REQ-038 Test 4, glitch: 2-cycle 000 inside green -> ignored, dwell continues; 3-cycle 000 -> err_illegal, phase = 3, phase_valid = 0.
REQ-039 Test 5, clr_err coincident with err_seq -> err_sticky = 001 afterwards; clr_err alone -> 000.
REQ-040 Test 6, sys_rst asserted mid-blue -> all outputs at reset values next cycle; following green exit not underrun-checked.
